// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer and debouncer with press/release pulses and a wrapping press counter.
// Optional hold-to-repeat press pulses are enabled by defining BTN_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int NBTN            = 7,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic            clk_25mhz,
    input  logic            rst,
    input  logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] state,
    output logic [NBTN-1:0] press,
    output logic [NBTN-1:0] rel,
    output logic [7:0]      press_cnt
);

    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  s1_q, s2_q;
    logic [NBTN-1:0]  state_q, state_d;
    logic [NBTN-1:0]  press_q, press_d;
    logic [NBTN-1:0]  rel_q, rel_d;
    logic [NBTN-1:0]  commit;
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];
    logic [7:0]       press_cnt_q, press_cnt_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    // Reloading here makes every later repeat land REPEAT_PERIOD cycles after the previous one.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_q [NBTN];
    logic [HOLD_W-1:0] hold_d [NBTN];
`endif

    always_comb begin
        state_d = state_q;
        press_d = '0;
        rel_d   = '0;
        commit  = '0;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_LAST) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i]   = '0;
                commit[i]  = 1'b1;
                state_d[i] = s2_q[i];
                if (s2_q[i]) begin
                    press_d[i] = 1'b1;
                end else begin
                    rel_d[i] = 1'b1;
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            hold_d[i] = hold_q[i];
            // A pending release suppresses the repeat that would land in the same cycle.
            if (!state_q[i] || commit[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] == HOLD_LAST) begin
                hold_d[i]  = HOLD_RELOAD;
                press_d[i] = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + HOLD_W'(1);
            end
`endif
        end
    end

    always_comb begin
        press_cnt_d = press_cnt_q;
        for (int i = 0; i < NBTN; i++) begin
            press_cnt_d = press_cnt_d + 8'(press_q[i]);
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            state_q     <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            press_cnt_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
                hold_q[i] <= '0;
`endif
            end
        end else begin
            s1_q        <= btn;
            s2_q        <= s1_q;
            state_q     <= state_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            press_cnt_q <= press_cnt_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
                hold_q[i] <= hold_d[i];
`endif
            end
        end
    end

    assign state     = state_q;
    assign press     = press_q;
    assign rel       = rel_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/repeat timings.
module tb_btn_debounce;

    logic       clk_25mhz = 1'b0;
    logic       rst;
    logic [6:0] btn;
    logic [6:0] state, press, rel;
    logic [7:0] press_cnt;

    int errors = 0;
    int checks = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    btn_debounce #(
        .NBTN(7), .DEBOUNCE_CYCLES(4), .CNT_W(3),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .rst(rst),
        .btn(btn),
        .state(state),
        .press(press),
        .rel(rel),
        .press_cnt(press_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pulses;
        int         npress;
        int         nrep;
        int         offs [4];

        // reset with all buttons held
        rst = 1'b1;
        btn = 7'h7F;
        ticks(3);
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_press", 32'(press), 32'h0);
        chk("rst_rel", 32'(rel), 32'h0);
        chk("rst_cnt", 32'(press_cnt), 32'h0);
        rst = 1'b0;
        ticks(5);
        chk("held_pre_state", 32'(state), 32'h0);
        tick();
        chk("held_state", 32'(state), 32'h7F);
        chk("held_press", 32'(press), 32'h7F);
        tick();
        chk("held_press_end", 32'(press), 32'h0);
        chk("held_cnt", 32'(press_cnt), 32'd7);
        btn = 7'h00;
        ticks(6);
        chk("held_rel", 32'(rel), 32'h7F);
        chk("held_rel_state", 32'(state), 32'h0);
        tick();
        chk("held_rel_end", 32'(rel), 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_cnt", 32'(press_cnt), 32'h0);

        // clean press / release of button 1
        btn = 7'h02;
        ticks(5);
        chk("clean_early", 32'(press), 32'h0);
        tick();
        chk("clean_press", 32'(press), 32'h02);
        chk("clean_state", 32'(state), 32'h02);
        tick();
        chk("clean_press_end", 32'(press), 32'h0);
        chk("clean_cnt", 32'(press_cnt), 32'd1);
        btn = 7'h00;
        ticks(5);
        chk("clean_rel_early", 32'(rel), 32'h0);
        tick();
        chk("clean_rel", 32'(rel), 32'h02);
        chk("clean_rel_state", 32'(state), 32'h0);

        // bouncing button 2
        pulses = '0;
        for (int p = 0; p < 4; p++) begin
            btn[2] = (p % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick();
                pulses |= press | rel;
            end
        end
        btn[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            pulses |= press | rel;
        end
        chk("bounce_quiet", 32'(pulses), 32'h0);
        tick();
        chk("bounce_press", 32'(press), 32'h04);
        tick();
        chk("bounce_cnt", 32'(press_cnt), 32'd2);

        // 3-cycle glitch on button 3
        pulses = '0;
        btn[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses |= press | rel;
        end
        btn[3] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            pulses |= press | rel;
        end
        chk("glitch_quiet", 32'(pulses), 32'h0);
        chk("glitch_state", 32'(state), 32'h04);
        btn = 7'h00;
        ticks(6);
        chk("bounce_rel", 32'(rel), 32'h04);
        tick();

        // wrap with simultaneous presses on buttons 0 and 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        npress = 0;
        for (int r = 0; r < 128; r++) begin
            if (r == 127) chk("wrap_cnt_254", 32'(press_cnt), 32'd254);
            btn = 7'h11;
            ticks(6);
            if (press == 7'h11) npress++;
            tick();
            btn = 7'h00;
            ticks(7);
        end
        chk("wrap_pulses", 32'(npress), 32'd128);
        chk("wrap_cnt_0", 32'(press_cnt), 32'd0);
        btn = 7'h11;
        ticks(7);
        chk("wrap_cnt_2", 32'(press_cnt), 32'd2);
        btn = 7'h00;
        ticks(7);

        // hold button 5; release lands where the fourth repeat would be
        btn = 7'h20;
        ticks(6);
        chk("hold_press", 32'(press), 32'h20);
        nrep = 0;
        for (int k = 0; k < 4; k++) offs[k] = 0;
        for (int k = 1; k <= 38; k++) begin
            tick();
            if (press[5]) begin
                if (nrep < 4) offs[nrep] = k;
                nrep++;
            end
        end
        btn = 7'h00;
        for (int k = 39; k <= 54; k++) begin
            tick();
            if (press[5]) nrep++;
            if (k == 44) begin
                chk("hold_rel", 32'(rel), 32'h20);
                chk("hold_rel_nopress", 32'(press), 32'h0);
            end
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("repeat_count", 32'(nrep), 32'd3);
        chk("repeat_first", 32'(offs[0]), 32'd20);
        chk("repeat_second", 32'(offs[1]), 32'd28);
        chk("repeat_third", 32'(offs[2]), 32'd36);
        chk("repeat_cnt", 32'(press_cnt), 32'd6);
`else
        chk("repeat_count", 32'(nrep), 32'd0);
        chk("repeat_cnt", 32'(press_cnt), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
